aes_engine_adapter: RTL and testbench
=====================================

Name: aes_engine_adapter

Overview:
Engine-side responder to the AES HWPE control FSM. It consumes ctrl_engine_t and reports flags_engine_t. It packs 32-bit words from the input streamer into 128-bit AES blocks, drives an external AES core through key expansion and block processing, and serialises each 128-bit result back to 32-bit words toward the output streamer. It sits between the streamer and the AES core inside the HWPE engine.

Parameters:
DATA_WIDTH, 32, streamer word width; only 32 is supported.
WORDS_PER_BLOCK, 4, words per 128-bit AES block; fixed at 128/DATA_WIDTH.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
ctrl_i  in  ctrl_engine_t  control from the FSM: clear, enable, core_encode_decode, core_init_key, core_start, core_key, core_key_mode, data_size (bytes)
flags_o  out  flags_engine_t  core_ready, core_done
in_data_i  in  32  input stream word
in_valid_i  in  1  input word valid
in_ready_o  out  1  input word accepted
out_data_o  out  32  output stream word
out_valid_o  out  1  output word valid
out_ready_i  in  1  output word accepted
aes_init_o  out  1  one-cycle key-expansion start to the core
aes_next_o  out  1  one-cycle block start to the core
aes_encdec_o  out  1  1 = encrypt, 0 = decrypt
aes_keylen_o  out  1  0 = 128-bit key, 1 = 256-bit key
aes_key_o  out  256  key to the core
aes_block_o  out  128  block to the core
aes_ready_i  in  1  core idle / key expansion complete
aes_result_i  in  128  core result
aes_result_valid_i  in  1  result valid

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0, block and result registers 0.
- ctrl_i.clear (synchronous) forces the same values as reset on the next edge, in any state. Clear has priority over enable.
- ctrl_i.enable=0 freezes every register. While frozen: in_ready_o=0, aes_init_o=0, aes_next_o=0, out_valid_o holds its value, out_data_o is stable.
- Start in IDLE (core_start=1), in the same cycle:
  - latch encdec, key_mode and key;
  - total_words = (data_size+3)>>2, computed 33 bits wide;
  - total_blocks = ceil(total_words/4).
- State transitions:
  - IDLE -> KEY_INIT if core_init_key=1; else GATHER.
  - If total_words=0: go to DONE directly, with no core activity.
- KEY_INIT: aes_init_o=1 for exactly one cycle -> KEY_WAIT.
- KEY_WAIT: wait for aes_ready_i=1 for at least one cycle after init -> GATHER.
- GATHER:
  - in_ready_o=1 while fewer than 4 words are held and words remain.
  - Word k of a block lands in bits [127-32k -: 32] (first word = MSW).
  - Last block with fewer than 4 remaining words: the missing words are zero-padded and no further input is requested.
  - Block complete and aes_ready_i=1 -> CORE_START.
- CORE_START: aes_next_o=1 for one cycle; aes_block_o holds stable until the result arrives -> CORE_WAIT.
- CORE_WAIT: on aes_result_valid_i=1, capture aes_result_i -> EMIT.
- EMIT:
  - out_valid_o=1 with word k = result[127-32k -: 32]; advance on out_valid_o & out_ready_i.
  - out_valid_o and out_data_o are stable while stalled.
  - Only the unpadded words of the last block are emitted.
  - After the last word of a block: -> DONE if no blocks remain, else -> GATHER.
  - No input is accepted during EMIT.
- DONE: flags_o.core_done=1 for exactly one cycle -> IDLE.
- flags_o.core_ready = (state==IDLE) & aes_ready_i.
- core_start outside IDLE is ignored.
- Reset asserted mid-operation: immediate return to reset values; the partial block is discarded.
- Latency, from the 4th input word accepted to the first out_valid_o: 2 cycles plus core latency.

Decomposition:
- aes_package gains aes_adapter_state_t (IDLE, KEY_INIT, KEY_WAIT, GATHER, CORE_START, CORE_WAIT, EMIT, DONE) and the constant AES_WORDS_PER_BLOCK=4.
- One sub-module is natural: aes_block_serializer (128-bit result register, 2-bit word index, valid/ready output stage).
- Packing, counters and the FSM stay in aes_engine_adapter.

Test Plan:
- AES-128 encrypt:
  - stimulus: key 000102030405060708090a0b0c0d0e0f (in core_key[255:128]), key_mode=0, init_key=1, data_size=16, input 00112233,44556677,8899aabb,ccddeeff;
  - response: one aes_init_o pulse, one aes_next_o pulse, output 69c4e0d8,6a7b0430,d8cdb780,70b4c55a, then core_done high for 1 cycle.
- Same key, decrypt, with the 4 ciphertext words above as input -> the plaintext words are returned in order.
- data_size=20:
  - 5 input words accepted, then in_ready_o stays 0;
  - second block = {w4,0,0,0};
  - exactly 5 output words, then core_done.
- data_size=0 with core_start -> no aes_init_o/aes_next_o, no in_ready_o; core_done asserted 2 cycles after start.
- Backpressure:
  - out_ready_i=0 for 5 cycles mid-EMIT -> out_data_o stable, no word lost or duplicated;
  - enable=0 for 3 cycles during GATHER -> no words accepted in those cycles.
- clear asserted in CORE_WAIT -> next cycle all outputs 0, state IDLE; a subsequent start processes correctly.

Source files
------------

// File: rtl/aes_package.sv
// Shared types for the AES HWPE engine: FSM/engine control, engine flags and
// the adapter state encoding.
package aes_package;

  localparam int unsigned AES_WORDS_PER_BLOCK = 4;

  typedef struct packed {
    logic         clear;
    logic         enable;
    logic         core_encode_decode;
    logic         core_init_key;
    logic         core_start;
    logic [255:0] core_key;
    logic         core_key_mode;
    logic [31:0]  data_size;
  } ctrl_engine_t;

  typedef struct packed {
    logic core_ready;
    logic core_done;
  } flags_engine_t;

  typedef enum logic [2:0] {
    StIdle,
    StKeyInit,
    StKeyWait,
    StGather,
    StCoreStart,
    StCoreWait,
    StEmit,
    StDone
  } aes_adapter_state_t;

  // Word k of a block sits at [127-32k -: 32], first word most significant.
  function automatic logic [31:0] block_word(input logic [127:0] blk, input logic [1:0] idx);
    logic [31:0] w;
    unique case (idx)
      2'd0: w = blk[127:96];
      2'd1: w = blk[95:64];
      2'd2: w = blk[63:32];
      2'd3: w = blk[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/aes_engine_adapter_serializer.sv
// Holds one 128-bit AES result and hands it out as 32-bit words over a
// valid/ready stage. Only the first nwords_i words of the block are emitted.
module aes_block_serializer
  import aes_package::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         enable_i,
  input  logic         load_i,
  input  logic [127:0] result_i,
  input  logic [2:0]   nwords_i,
  input  logic         out_ready_i,
  output logic [31:0]  out_data_o,
  output logic         out_valid_o,
  output logic         last_o
);

  logic [127:0] result_q;
  logic [1:0]   idx_q;
  logic [2:0]   nwords_q;
  logic         valid_q;

  // Word currently presented is the last unpadded word of the block
  assign last_o      = valid_q & ({1'b0, idx_q} == (nwords_q - 3'd1));
  assign out_valid_o = valid_q;
  assign out_data_o  = block_word(result_q, idx_q);

  // Result capture and word-index advance; frozen entirely while disabled
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q <= '0;
      idx_q    <= '0;
      nwords_q <= '0;
      valid_q  <= 1'b0;
    end else if (clear_i) begin
      result_q <= '0;
      idx_q    <= '0;
      nwords_q <= '0;
      valid_q  <= 1'b0;
    end else if (enable_i) begin
      if (load_i) begin
        result_q <= result_i;
        idx_q    <= '0;
        nwords_q <= nwords_i;
        valid_q  <= 1'b1;
      end else if (valid_q && out_ready_i) begin
        if (last_o) begin
          valid_q <= 1'b0;
          idx_q   <= '0;
        end else begin
          idx_q <= idx_q + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/aes_engine_adapter.sv
// Engine-side adapter between the HWPE streamers and an external AES core:
// packs input words into blocks, sequences key expansion and block runs, and
// returns results word by word through aes_block_serializer.
module aes_engine_adapter
  import aes_package::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned WORDS_PER_BLOCK = AES_WORDS_PER_BLOCK
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  ctrl_engine_t          ctrl_i,
  output flags_engine_t         flags_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  aes_init_o,
  output logic                  aes_next_o,
  output logic                  aes_encdec_o,
  output logic                  aes_keylen_o,
  output logic [255:0]          aes_key_o,
  output logic [127:0]          aes_block_o,
  input  logic                  aes_ready_i,
  input  logic [127:0]          aes_result_i,
  input  logic                  aes_result_valid_i
);

  localparam logic [2:0] FullCnt = 3'(WORDS_PER_BLOCK);

  aes_adapter_state_t state_q, state_d;

  logic         encdec_q;
  logic         keylen_q;
  logic [255:0] key_q;
  logic [127:0] block_q;
  logic [2:0]   held_q;
  logic [32:0]  words_rem_q;
  logic [32:0]  blocks_rem_q;
  logic [32:0]  total_words;
  logic [32:0]  total_blocks;
  logic         start;
  logic         accept;
  logic         blk_full;
  logic         ser_load;
  logic         ser_last;
  logic         emit_last;

  assign total_words  = ({1'b0, ctrl_i.data_size} + 33'd3) >> 2;
  assign total_blocks = (total_words + 33'd3) >> 2;
  assign start        = (state_q == StIdle) & ctrl_i.core_start;
  assign accept       = in_valid_i & in_ready_o;
  // A short final block counts as full once the input is exhausted
  assign blk_full     = (held_q == FullCnt) | ((words_rem_q == '0) & (held_q != '0));
  assign ser_load     = (state_q == StCoreWait) & aes_result_valid_i;
  assign emit_last    = out_valid_o & out_ready_i & ser_last;

  assign aes_encdec_o = encdec_q;
  assign aes_keylen_o = keylen_q;
  assign aes_key_o    = key_q;
  assign aes_block_o  = block_q;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else if (ctrl_i.clear) begin
      state_q <= StIdle;
    end else if (ctrl_i.enable) begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ctrl_i.core_start) begin
          if (total_words == '0)       state_d = StDone;
          else if (ctrl_i.core_init_key) state_d = StKeyInit;
          else                           state_d = StGather;
        end
      end
      StKeyInit:   state_d = StKeyWait;
      StKeyWait:   if (aes_ready_i) state_d = StGather;
      StGather:    if (blk_full && aes_ready_i) state_d = StCoreStart;
      StCoreStart: state_d = StCoreWait;
      StCoreWait:  if (aes_result_valid_i) state_d = StEmit;
      StEmit: begin
        if (emit_last) state_d = (blocks_rem_q == 33'd1) ? StDone : StGather;
      end
      StDone:      state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    in_ready_o         = ctrl_i.enable & ~ctrl_i.clear & (state_q == StGather) &
                         (held_q < FullCnt) & (words_rem_q != '0);
    aes_init_o         = ctrl_i.enable & (state_q == StKeyInit);
    aes_next_o         = ctrl_i.enable & (state_q == StCoreStart);
    flags_o.core_done  = ctrl_i.enable & (state_q == StDone);
    flags_o.core_ready = (state_q == StIdle) & aes_ready_i;
  end

  // Job parameters, block packing and word/block counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      encdec_q     <= 1'b0;
      keylen_q     <= 1'b0;
      key_q        <= '0;
      block_q      <= '0;
      held_q       <= '0;
      words_rem_q  <= '0;
      blocks_rem_q <= '0;
    end else if (ctrl_i.clear) begin
      encdec_q     <= 1'b0;
      keylen_q     <= 1'b0;
      key_q        <= '0;
      block_q      <= '0;
      held_q       <= '0;
      words_rem_q  <= '0;
      blocks_rem_q <= '0;
    end else if (ctrl_i.enable) begin
      if (start) begin
        encdec_q     <= ctrl_i.core_encode_decode;
        keylen_q     <= ctrl_i.core_key_mode;
        key_q        <= ctrl_i.core_key;
        words_rem_q  <= total_words;
        blocks_rem_q <= total_blocks;
        block_q      <= '0;
        held_q       <= '0;
      end
      if (accept) begin
        unique case (held_q[1:0])
          2'd0: block_q[127:96] <= in_data_i;
          2'd1: block_q[95:64]  <= in_data_i;
          2'd2: block_q[63:32]  <= in_data_i;
          2'd3: block_q[31:0]   <= in_data_i;
        endcase
        held_q      <= held_q + 3'd1;
        words_rem_q <= words_rem_q - 33'd1;
      end
      // Zeroing here gives the padding for a short final block
      if (emit_last) begin
        blocks_rem_q <= blocks_rem_q - 33'd1;
        block_q      <= '0;
        held_q       <= '0;
      end
    end
  end

  aes_block_serializer u_serializer (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (ctrl_i.clear),
    .enable_i    (ctrl_i.enable),
    .load_i      (ser_load),
    .result_i    (aes_result_i),
    .nwords_i    (held_q),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .last_o      (ser_last)
  );

endmodule

// File: tb/tb_aes_engine_adapter.sv
// Self-checking bench for aes_engine_adapter with a behavioural AES core model
// and a scoreboard of expected output words.
module tb_aes_engine_adapter;
  import aes_package::*;

  localparam logic [127:0] Pt   = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] Ct   = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [255:0] Key  = {128'h00010203_04050607_08090a0b_0c0d0e0f, 128'h0};
  localparam logic [127:0] Mask = 128'hdeadbeef_0badf00d_12345678_9abcdef0;
  localparam int KeyLat  = 6;
  localparam int CoreLat = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ctrl_engine_t  ctrl;
  flags_engine_t flags;
  logic [31:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         aes_init, aes_next, aes_encdec, aes_keylen;
  logic [255:0] aes_key;
  logic [127:0] aes_block;
  logic         aes_ready = 1'b1;
  logic [127:0] aes_result = '0;
  logic         aes_result_valid = 1'b0;

  int n_total = 0;
  int n_bad   = 0;
  int n_done  = 0;
  int n_init  = 0;
  int n_next  = 0;
  logic [31:0]  sb[$];
  logic [127:0] blocks_seen[$];

  aes_engine_adapter dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .ctrl_i             (ctrl),
    .flags_o            (flags),
    .in_data_i          (in_data),
    .in_valid_i         (in_valid),
    .in_ready_o         (in_ready),
    .out_data_o         (out_data),
    .out_valid_o        (out_valid),
    .out_ready_i        (out_ready),
    .aes_init_o         (aes_init),
    .aes_next_o         (aes_next),
    .aes_encdec_o       (aes_encdec),
    .aes_keylen_o       (aes_keylen),
    .aes_key_o          (aes_key),
    .aes_block_o        (aes_block),
    .aes_ready_i        (aes_ready),
    .aes_result_i       (aes_result),
    .aes_result_valid_i (aes_result_valid)
  );

  // Stand-in for the AES core: FIPS-197 vector pair, otherwise a simple mask
  function automatic logic [127:0] core_fn(input logic [127:0] b, input logic enc);
    if (enc && b == Pt) return Ct;
    if (!enc && b == Ct) return Pt;
    return enc ? (b ^ Mask) : ({b[63:0], b[127:64]} ^ Mask);
  endfunction

  int           core_cnt = 0;
  logic         pend_blk = 1'b0;
  logic [127:0] pend_res = '0;

  always @(posedge clk) begin
    aes_result_valid <= 1'b0;
    if (aes_init) begin
      aes_ready <= 1'b0;
      core_cnt  <= KeyLat;
      pend_blk  <= 1'b0;
      n_init    <= n_init + 1;
    end else if (aes_next) begin
      aes_ready <= 1'b0;
      core_cnt  <= CoreLat;
      pend_blk  <= 1'b1;
      pend_res  <= core_fn(aes_block, aes_encdec);
      n_next    <= n_next + 1;
      blocks_seen.push_back(aes_block);
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end else if (core_cnt == 1) begin
      core_cnt  <= 0;
      aes_ready <= 1'b1;
      if (pend_blk) begin
        aes_result_valid <= 1'b1;
        aes_result       <= pend_res;
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pops the scoreboard on every output handshake
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n && ctrl.enable && !ctrl.clear) begin
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("out_extra", 256'(sb.size()), 256'd1);
          else chk("out_word", 256'(out_data), 256'(sb.pop_front()));
        end
        if (flags.core_done) n_done++;
      end
    end
  endtask

  task automatic push_block(input logic [127:0] b, input logic enc, input int n);
    logic [127:0] r;
    r = core_fn(b, enc);
    for (int k = 0; k < n; k++) sb.push_back(32'(r >> (96 - 32 * k)));
  endtask

  task automatic send_word(input logic [31:0] w);
    int t;
    t = 0;
    in_data  = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clk);
    end
    if (t >= 200) chk("in_timeout", 256'(t), 256'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!flags.core_ready && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("core_ready", 256'(flags.core_ready), 256'd1);
  endtask

  task automatic start_op(input logic enc, input logic init, input logic [31:0] size);
    ctrl.core_encode_decode = enc;
    ctrl.core_init_key      = init;
    ctrl.data_size          = size;
    ctrl.core_key           = Key;
    ctrl.core_key_mode      = 1'b0;
    ctrl.core_start         = 1'b1;
    @(posedge clk);
    #1;
    ctrl.core_start = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int t;
    t = 0;
    while (n_done == d0 && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", 256'(n_done - d0), 256'd1);
    chk("sb_empty", 256'(sb.size()), 256'd0);
  endtask

  // Known-answer encrypt (or decrypt) of one block with key expansion
  task automatic run_kat(input logic enc);
    int d0, i0, n0;
    logic [127:0] src, dst;
    src = enc ? Pt : Ct;
    dst = enc ? Ct : Pt;
    wait_idle();
    d0 = n_done; i0 = n_init; n0 = n_next;
    for (int k = 0; k < 4; k++) sb.push_back(32'(dst >> (96 - 32 * k)));
    start_op(enc, 1'b1, 32'd16);
    chk("key_latch", aes_key, Key);
    chk("encdec_latch", 256'(aes_encdec), 256'(enc));
    for (int k = 0; k < 4; k++) send_word(32'(src >> (96 - 32 * k)));
    wait_done(d0);
    chk("init_pulses", 256'(n_init - i0), 256'd1);
    chk("next_pulses", 256'(n_next - n0), 256'd1);
  endtask

  initial begin
    logic [31:0]  w[5];
    logic [31:0]  snap;
    logic [127:0] b;
    logic         act;
    int           d0, n0, i0, t;

    ctrl = '0;
    ctrl.enable = 1'b1;
    fork
      monitor();
    join_none

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 256'(out_valid), 256'd0);
    chk("rst_in_ready", 256'(in_ready), 256'd0);
    chk("rst_out_data", 256'(out_data), 256'd0);
    chk("rst_done", 256'(flags.core_done), 256'd0);
    chk("rst_key", aes_key, 256'd0);
    chk("rst_init_next", 256'({aes_init, aes_next}), 256'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_kat(1'b1);
    run_kat(1'b0);

    // 20 bytes: five words, second block zero-padded, five outputs
    wait_idle();
    for (int k = 0; k < 5; k++) w[k] = $urandom;
    d0 = n_done; i0 = n_init; n0 = n_next;
    push_block({w[0], w[1], w[2], w[3]}, 1'b1, 4);
    push_block({w[4], 96'h0}, 1'b1, 1);
    start_op(1'b1, 1'b0, 32'd20);
    for (int k = 0; k < 5; k++) send_word(w[k]);
    act = 1'b0;
    repeat (6) begin
      @(negedge clk);
      act = act | in_ready;
    end
    chk("sz20_no_more_in", 256'(act), 256'd0);
    wait_done(d0);
    chk("sz20_pad_block", 256'(blocks_seen[$]), 256'({w[4], 96'h0}));
    chk("sz20_next", 256'(n_next - n0), 256'd2);
    chk("sz20_no_init", 256'(n_init - i0), 256'd0);

    // Zero-length job: straight to done with no core or stream activity
    wait_idle();
    d0 = n_done; i0 = n_init; n0 = n_next;
    start_op(1'b1, 1'b1, 32'd0);
    act = 1'b0;
    repeat (4) begin
      @(negedge clk);
      act = act | in_ready | aes_init | aes_next;
    end
    chk("zero_no_activity", 256'(act), 256'd0);
    chk("zero_done", 256'(n_done - d0), 256'd1);
    chk("zero_core_calls", 256'(n_init - i0 + n_next - n0), 256'd0);
    @(posedge clk);
    #1;

    // Output backpressure mid-emit
    wait_idle();
    for (int k = 0; k < 4; k++) w[k] = $urandom;
    b = {w[0], w[1], w[2], w[3]};
    d0 = n_done;
    push_block(b, 1'b1, 4);
    start_op(1'b1, 1'b0, 32'd16);
    for (int k = 0; k < 4; k++) send_word(w[k]);
    t = 0;
    @(negedge clk);
    while (!out_valid && t < 100) begin
      t++;
      @(negedge clk);
    end
    chk("bp_valid_seen", 256'(out_valid), 256'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    snap = out_data;
    chk("bp_word1", 256'(snap), 256'(32'(core_fn(b, 1'b1) >> 64)));
    repeat (4) begin
      @(negedge clk);
      chk("bp_stable", 256'(out_data), 256'(snap));
      chk("bp_valid_held", 256'(out_valid), 256'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done(d0);

    // Enable low for three cycles while gathering
    wait_idle();
    for (int k = 0; k < 4; k++) w[k] = $urandom;
    d0 = n_done;
    push_block({w[0], w[1], w[2], w[3]}, 1'b0, 4);
    start_op(1'b0, 1'b0, 32'd16);
    send_word(w[0]);
    send_word(w[1]);
    ctrl.enable = 1'b0;
    in_data     = w[2];
    in_valid    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("frz_in_ready", 256'(in_ready), 256'd0);
    end
    @(posedge clk);
    #1;
    ctrl.enable = 1'b1;
    send_word(w[2]);
    send_word(w[3]);
    wait_done(d0);

    // Clear while waiting on the core, then a clean rerun
    wait_idle();
    for (int k = 0; k < 4; k++) w[k] = $urandom;
    d0 = n_done; n0 = n_next;
    start_op(1'b1, 1'b1, 32'd16);
    for (int k = 0; k < 4; k++) send_word(w[k]);
    t = 0;
    while (n_next == n0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("clr_next_seen", 256'(n_next - n0), 256'd1);
    ctrl.clear = 1'b1;
    @(posedge clk);
    #1;
    ctrl.clear = 1'b0;
    @(negedge clk);
    chk("clr_out_valid", 256'(out_valid), 256'd0);
    chk("clr_out_data", 256'(out_data), 256'd0);
    chk("clr_key", aes_key, 256'd0);
    chk("clr_block", 256'(aes_block), 256'd0);
    chk("clr_ctl", 256'({in_ready, aes_init, aes_next, flags.core_done, aes_encdec}), 256'd0);
    repeat (CoreLat + 2) @(negedge clk);
    chk("clr_no_output", 256'(out_valid), 256'd0);
    chk("clr_no_done", 256'(n_done - d0), 256'd0);
    @(posedge clk);
    #1;
    run_kat(1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
